// File: rtl/riptide_pcache_pkg.sv
// Shared geometry and FSM encoding for the riptide program cache.
package riptide_pcache_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_COUNT = 64;
  localparam int OFF_W      = 2;
  localparam int IDX_W      = 6;
  localparam int TAG_W      = 8;
  localparam int LINE_W     = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_RESTART = 2'd2
  } pcache_state_e;

endpackage

// File: rtl/riptide_pcache_ram.sv
// Data array (256x16) and tag array (64x8) with synchronous reads.
// The read registers are reset so the instruction output is zero while RST is high.
module riptide_pcache_ram
  import riptide_pcache_pkg::*;
(
  input  logic                     clk,
  input  logic                     RST,
  input  logic [IDX_W+OFF_W-1:0]   rd_addr_i,
  input  logic                     data_we_i,
  input  logic [IDX_W+OFF_W-1:0]   data_waddr_i,
  input  logic [DATA_W-1:0]        data_wdata_i,
  input  logic                     tag_we_i,
  input  logic [IDX_W-1:0]         tag_widx_i,
  input  logic [TAG_W-1:0]         tag_wdata_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic [TAG_W-1:0]         rd_tag_o
);

  logic [DATA_W-1:0] data_mem [0:LINE_COUNT*LINE_WORDS-1];
  logic [TAG_W-1:0]  tag_mem  [0:LINE_COUNT-1];
  logic [DATA_W-1:0] rd_data_q;
  logic [TAG_W-1:0]  rd_tag_q;

  // Array write ports, driven by the refill sequencer
  always_ff @(posedge clk) begin
    if (data_we_i) begin
      data_mem[data_waddr_i] <= data_wdata_i;
    end
    if (tag_we_i) begin
      tag_mem[tag_widx_i] <= tag_wdata_i;
    end
  end

  // Synchronous read of the word and its line tag
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rd_data_q <= '0;
      rd_tag_q  <= '0;
    end else begin
      rd_data_q <= data_mem[rd_addr_i];
      rd_tag_q  <= tag_mem[rd_addr_i[IDX_W+OFF_W-1:OFF_W]];
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_tag_o  = rd_tag_q;

endmodule

// File: rtl/riptide_pcache.sv
// Direct-mapped program cache: 64 lines x 4 words, 1-cycle hit, line refill
// from backing memory on a miss. Optional flush port: RIPTIDE_PCACHE_FLUSH_EN.
module riptide_pcache
  import riptide_pcache_pkg::*;
(
  input  logic              clk,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] I,
  output logic              p_cache_miss,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data
`ifdef RIPTIDE_PCACHE_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  pcache_state_e           state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [OFF_W-1:0]        cnt_q, cnt_d;
  logic [LINE_COUNT-1:0]   valid_q, valid_d;
  logic                    rd_vld_q;

  logic [IDX_W+OFF_W-1:0]  rd_addr_s;
  logic [DATA_W-1:0]       rd_data_s;
  logic [TAG_W-1:0]        rd_tag_s;
  logic [IDX_W-1:0]        cur_idx_s, line_idx_s;
  logic [TAG_W-1:0]        cur_tag_s, line_tag_s;
  logic                    hit_s, fill_ack_s, last_ack_s;
  logic                    flush_s, flush_pend_s;

  assign cur_idx_s  = addr_q[OFF_W +: IDX_W];
  assign cur_tag_s  = addr_q[ADDR_W-1 -: TAG_W];
  assign line_idx_s = line_q[IDX_W-1:0];
  assign line_tag_s = line_q[IDX_W +: TAG_W];

  // In IDLE the arrays follow the live address; otherwise they re-read the held one.
  assign rd_addr_s  = (state_q == ST_IDLE) ? A[IDX_W+OFF_W-1:0] : addr_q[IDX_W+OFF_W-1:0];
  // rd_vld_q keeps the first post-reset cycle from being treated as a real lookup.
  assign hit_s      = rd_vld_q && valid_q[cur_idx_s] && (rd_tag_s == cur_tag_s);
  assign fill_ack_s = (state_q == ST_FILL) && mem_ack;
  assign last_ack_s = fill_ack_s && (cnt_q == 2'd3);

`ifdef RIPTIDE_PCACHE_FLUSH_EN
  logic flush_pend_q, flush_pend_d;
  assign flush_s      = flush;
  assign flush_pend_s = flush_pend_q;
  assign flush_pend_d = (state_q == ST_FILL) ? (flush_pend_q | flush) : 1'b0;

  // Remember a flush seen mid-fill so the line being filled stays invalid
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
    end
  end
`else
  assign flush_s      = 1'b0;
  assign flush_pend_s = 1'b0;
`endif

  // Next-state logic for the lookup / refill sequencer and the valid bits
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        addr_d = A;
        if (rd_vld_q && !hit_s) begin
          state_d = ST_FILL;
          line_d  = addr_q[ADDR_W-1:OFF_W];
          cnt_d   = 2'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (fill_ack_s) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_RESTART;
            if (flush_pend_s) begin
              valid_d = valid_q;
            end else begin
              valid_d[line_idx_s] = 1'b1;
            end
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_RESTART: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A flush in any state wipes every line, including one completing this cycle.
    if (flush_s) begin
      valid_d = '0;
    end else begin
      valid_d = valid_d;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      line_q   <= '0;
      cnt_q    <= '0;
      valid_q  <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      line_q   <= line_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      rd_vld_q <= 1'b1;
    end
  end

  riptide_pcache_ram u_ram (
    .clk          (clk),
    .RST          (RST),
    .rd_addr_i    (rd_addr_s),
    .data_we_i    (fill_ack_s),
    .data_waddr_i ({line_idx_s, cnt_q}),
    .data_wdata_i (mem_data),
    .tag_we_i     (last_ack_s),
    .tag_widx_i   (line_idx_s),
    .tag_wdata_i  (line_tag_s),
    .rd_data_o    (rd_data_s),
    .rd_tag_o     (rd_tag_s)
  );

  assign I            = rd_data_s;
  assign p_cache_miss = (state_q == ST_IDLE) ? !hit_s : 1'b1;
  assign mem_req      = (state_q == ST_FILL);
  assign mem_addr     = {line_q, cnt_q};

endmodule

// File: tb/tb_riptide_pcache.sv
// Self-checking bench for riptide_pcache: directed scenarios followed by a
// randomized fetch stream, checked against a tag/valid reference model.
module tb_riptide_pcache;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] A = 16'h0000;
  logic [15:0] I;
  logic        p_cache_miss;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_data;
`ifdef RIPTIDE_PCACHE_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Responder log: address seen at request and at acknowledge for each read
  logic [15:0] req_log [0:4095];
  logic [15:0] ack_log [0:4095];
  int          rd_cnt    = 0;
  int          inj_req   = 0;
  int          inj_done  = 0;
  bit          fixed_lat = 1'b1;
  logic [15:0] resp_a;
  int          resp_lat;
  bit          resp_abort;

  // Reference model: one valid bit and tag per line
  bit          mv [64];
  logic [7:0]  mt [64];

  riptide_pcache dut (
    .clk          (clk),
    .RST          (RST),
    .A            (A),
    .I            (I),
    .p_cache_miss (p_cache_miss),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data)
`ifdef RIPTIDE_PCACHE_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Backing memory: answers each request after a latency, or injects a stray ack
  initial begin : responder
    mem_ack  = 1'b0;
    mem_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (mem_req && !RST) begin
        resp_a     = mem_addr;
        resp_lat   = fixed_lat ? 3 : int'($urandom_range(4, 1));
        resp_abort = 1'b0;
        for (int k = 1; k < resp_lat; k++) begin
          @(negedge clk);
          if (RST) resp_abort = 1'b1;
        end
        if (!resp_abort && !RST && mem_req) begin
          req_log[rd_cnt] = resp_a;
          ack_log[rd_cnt] = mem_addr;
          mem_data = memf(mem_addr);
          mem_ack  = 1'b1;
          rd_cnt   = rd_cnt + 1;
          @(negedge clk);
          mem_ack  = 1'b0;
          mem_data = 16'h0000;
        end
      end else if (inj_req != inj_done) begin
        mem_data = 16'hDEAD;
        mem_ack  = 1'b1;
        inj_done = inj_done + 1;
        @(negedge clk);
        mem_ack  = 1'b0;
        mem_data = 16'h0000;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mv[i]) mv[i] = 1'b0;
  endtask

  task automatic model_access(input logic [15:0] a, output int exp_reads);
    int idx;
    idx = int'(a[7:2]);
    if (mv[idx] && mt[idx] == a[15:8]) begin
      exp_reads = 0;
    end else begin
      exp_reads = 4;
      mv[idx] = 1'b1;
      mt[idx] = a[15:8];
    end
  endtask

  // Present an address, wait (bounded) for the cache to deliver, check result and reads
  task automatic fetch(input string tag, input logic [15:0] a, input int exp_reads);
    int start;
    int cyc;
    bit done;
    start = rd_cnt;
    cyc   = 0;
    done  = 1'b0;
    A = a;
    @(posedge clk);
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (!p_cache_miss) done = 1'b1;
    end
    chk({tag, ":done"}, 32'(done), 32'd1);
    chk({tag, ":I"}, 32'(I), 32'(memf(a)));
    chk({tag, ":nreads"}, 32'(rd_cnt - start), 32'(exp_reads));
    for (int j = 0; j < exp_reads && j < rd_cnt - start; j++) begin
      chk({tag, ":raddr"}, 32'(ack_log[start + j]), 32'({a[15:2], 2'(j % 4)}));
      chk({tag, ":rstable"}, 32'(req_log[start + j]), 32'(ack_log[start + j]));
    end
    if (exp_reads == 0) chk({tag, ":lat"}, 32'(cyc), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic mfetch(input string tag, input logic [15:0] a);
    int e;
    model_access(a, e);
    fetch(tag, a, e);
  endtask

  task automatic wait_reads(input int target);
    int n;
    n = 0;
    while (rd_cnt < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("wait_reads", 32'(rd_cnt >= target), 32'd1);
  endtask

  initial begin : main
    int start;
    int n;
    logic [7:0] tags [4];
    logic [15:0] ra;
    tags[0] = 8'h12; tags[1] = 8'h22; tags[2] = 8'h31; tags[3] = 8'h40;
    model_clear();

    // Reset state
    #2 RST = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:mem_req", 32'(mem_req), 32'd0);
    chk("rst:mem_addr", 32'(mem_addr), 32'd0);
    chk("rst:I", 32'(I), 32'd0);
    chk("rst:miss", 32'(p_cache_miss), 32'd1);
    @(posedge clk);
    #1 RST = 1'b0;

    // Cold miss then hit streaming
    mfetch("cold", 16'h1234);
    mfetch("hit1", 16'h1235);
    mfetch("hit2", 16'h1236);
    mfetch("hit3", 16'h1237);

    // Tag conflict on the same index
    mfetch("conf_a", 16'h2234);
    mfetch("conf_b", 16'h1234);

    // Stray ack while idle must not touch the arrays
    inj_req = inj_req + 1;
    n = 0;
    while (inj_done != inj_req && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("inj_done", 32'(inj_done == inj_req), 32'd1);
    @(posedge clk);
    #1;
    mfetch("ackign", 16'h1234);

    // Reset during a fill: abort, no partial line, then a clean refill
    mfetch("pre_rst", 16'h2234);
    A = 16'h1234;
    start = rd_cnt;
    wait_reads(start + 2);
    #1 RST = 1'b1;
    #1;
    chk("midrst:mem_req", 32'(mem_req), 32'd0);
    chk("midrst:miss", 32'(p_cache_miss), 32'd1);
    chk("midrst:mem_addr", 32'(mem_addr), 32'd0);
    model_clear();
    repeat (3) @(posedge clk);
    chk("midrst:noreads", 32'(rd_cnt - start), 32'd2);
    #1 RST = 1'b0;
    mfetch("post_rst", 16'h1234);

`ifdef RIPTIDE_PCACHE_FLUSH_EN
    // Flush during the third beat: fill completes, then re-miss and refill
    mfetch("pre_fl", 16'h2234);
    start = rd_cnt;
    fork
      fetch("flfill", 16'h1234, 8);
      begin
        wait_reads(start + 2);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
      end
    join
    model_clear();
    mv[13] = 1'b1;
    mt[13] = 8'h12;

    // Flush while idle on a hit: miss rises the cycle after
    mfetch("fl_hit", 16'h1235);
    flush = 1'b1;
    @(negedge clk);
    chk("flidle:still_hit", 32'(p_cache_miss), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    chk("flidle:miss", 32'(p_cache_miss), 32'd1);
    model_clear();
    mfetch("fl_refill", 16'h1235);
`endif

    // Randomized fetch stream with variable memory latency
    fixed_lat = 1'b0;
    for (int t = 0; t < 60; t++) begin
      ra = {tags[$urandom_range(3, 0)], 4'h0, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0))};
      mfetch("rand", ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riptide_pcache.md
RIPTIDE_PCACHE -- requirements
Module: riptide_pcache

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock shared with the CPU core.
REQ-002 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port A  input  16  CPU program address.
REQ-004 SHALL have port I  output  16  instruction word to the CPU.
REQ-005 SHALL have port p_cache_miss  output  1  high while I is not valid for the current A; the CPU stalls and holds A stable.
REQ-006 SHALL have port mem_addr  output  16  backing program memory word address.
REQ-007 SHALL have port mem_req  output  1  read request, held until acknowledged.
REQ-008 SHALL have port mem_ack  input  1  one-cycle pulse; mem_data is valid in the same cycle.
REQ-009 SHALL have port mem_data  input  16  backing memory read data.
REQ-010 SHALL have port flush  input  1  invalidate-all pulse; present only with RIPTIDE_PCACHE_FLUSH_EN.

Function
REQ-011 SHALL be direct-mapped: 64 lines of 4 words (256 words); offset A[1:0], index A[7:2], tag A[15:8]; one valid bit per line.
REQ-012 SHALL register A on every clk edge while the FSM is in IDLE; the tag/data arrays are synchronous-read.
REQ-013 SHALL compute hit from the registered address as valid[idx] AND stored tag equal to the registered tag; in IDLE, p_cache_miss SHALL equal NOT hit, and I SHALL equal the data-array word.
REQ-014 SHALL have hit latency of 1 cycle, A at edge n giving I and p_cache_miss=0 after edge n+1, with back-to-back hits sustained at 1 word per cycle.
REQ-015 SHALL implement FSM states IDLE, FILL and RESTART.
REQ-016 SHALL move IDLE -> FILL on a miss, latching the line base address {tag, index, 2'b00}.
REQ-017 SHALL, in FILL, fetch offsets 0,1,2,3 in order: mem_addr = base + count, mem_req=1, and on each mem_ack write mem_data into the data array at that offset and increment the 2-bit count.
REQ-018 SHALL, on the mem_ack for offset 3, write the tag, set valid[idx] and go to RESTART.
REQ-019 SHALL, in RESTART, re-read the arrays at the latched address for one cycle, then return to IDLE, where hit is asserted.
REQ-020 SHALL hold p_cache_miss=1 continuously from miss detection through RESTART; the miss penalty is 4 acknowledges plus 2 cycles.
REQ-021 SHALL drop mem_req in the same cycle as the final mem_ack and keep it low outside FILL; mem_addr SHALL be stable while mem_req=1.
REQ-022 SHALL ignore mem_ack when not in FILL.
REQ-023 SHALL tolerate A changing during a miss by taking the registered post-RESTART address as authoritative, so a new miss re-enters FILL.
REQ-024 SHALL refill the line fully on a tag conflict in the same index, overwriting the old line.

Reset
REQ-025 SHALL, while RST is high, put the FSM in IDLE, clear all 64 valid bits, clear the fill count, and drive mem_req=0, mem_addr=0, I=0 and p_cache_miss=1.
REQ-026 SHALL, on RST asserted mid-FILL, abort immediately without waiting for mem_ack, leaving no partial line valid.
REQ-027 SHALL, after RST deasserts, give the first fetch a miss.

Configuration
REQ-028 SHALL, with RIPTIDE_PCACHE_FLUSH_EN defined, clear all valid bits on a flush pulse in IDLE on the next edge; if that cycle is a hit, p_cache_miss SHALL rise on the following cycle.
REQ-029 SHALL, on flush during FILL/RESTART with RIPTIDE_PCACHE_FLUSH_EN, complete the fill, clear all valid bits, leave the filled line invalid (flush wins), and re-miss after RESTART.
REQ-030 SHALL, without RIPTIDE_PCACHE_FLUSH_EN, omit the flush port and logic; invalidation then occurs only through RST.

Structure
REQ-031 SHALL place in a shared package the geometry constants (line words 4, line count 64, tag/index/offset widths) and the FSM state enum.
REQ-032 SHALL use one sub-module, riptide_pcache_ram: a 256x16 data array with a synchronous read port and a write port, paired with a 64x8 tag array; the valid bits stay in riptide_pcache flops.

Verification
REQ-033 SHALL cover cold miss: release RST, A=0x1234, mem_ack 3 cycles after each mem_req -> reads at 0x1234..0x1237, I=mem word[0x1234], p_cache_miss drops.
REQ-034 SHALL cover hit streaming: after the cold miss, A=0x1235, 0x1236, 0x1237 on consecutive cycles -> 3 words, p_cache_miss=0, no mem_req.
REQ-035 SHALL cover conflict: A=0x2234 then 0x1234 -> two full refills; the second returns the 0x1234 data.
REQ-036 SHALL cover reset mid-fill: RST after 2nd mem_ack of line 0x1234 -> mem_req=0; a subsequent 0x1234 fetch misses and issues 4 new reads.
REQ-037 SHALL cover flush (RIPTIDE_PCACHE_FLUSH_EN): a flush pulse during 3rd beat -> fill completes, then re-miss on 0x1234 with 4 more reads.
REQ-038 SHALL cover ack ignore: mem_ack pulsed in IDLE -> no array write; the subsequent hit returns the original data.
